// File: rtl/img_drawer_pkg.sv
// Shared types and helpers for the banked VGA image drawer.
package img_drawer_pkg;

    // Pipeline depth excluding memory latency: S0, S1, output register.
    localparam int BASE_LAT = 3;

    typedef logic [7:0] pixel_t;
    typedef logic [9:0] coord_t;

    // Index width for a power-of-two depth or a bank count; never below 1.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/img_bank_mux.sv
// Registered NUM_BANKS-way word select with fill-colour override.
module img_bank_mux #(
    parameter int NUM_BANKS = 4,
    parameter int PIX_W     = 8,
    parameter int SEL_W     = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [SEL_W-1:0]           sel,
    input  logic                       fill,
    input  logic [PIX_W-1:0]           fill_color,
    input  logic [NUM_BANKS*PIX_W-1:0] rdata,
    output logic [PIX_W-1:0]           pixel,
    output logic                       pixel_valid
);

    logic [PIX_W-1:0] word_c;

    // Pick the returning bank word; sel is only in range when fill is low.
    always_comb begin
        word_c = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (sel == SEL_W'(i)) word_c = rdata[i*PIX_W +: PIX_W];
        end
    end

    // Output register: framebuffer word or fill colour.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pixel       <= '0;
            pixel_valid <= 1'b0;
        end else if (fill) begin
            pixel       <= fill_color;
            pixel_valid <= 1'b0;
        end else begin
            pixel       <= word_c;
            pixel_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/img_drawer_banked.sv
// Banked framebuffer drawer: raster -> shared bank address -> registered pixel.
// Optional feature: define IMG_DRAWER_BORDER_EN to add a border_color port
// that paints a 1-pixel ring just outside the image window.
module img_drawer_banked
    import img_drawer_pkg::*;
#(
    parameter int IMG_W      = 320,
    parameter int IMG_H      = 240,
    parameter int H_OFF      = 112,
    parameter int V_OFF      = 13,
    parameter int NUM_BANKS  = 4,
    parameter int BANK_DEPTH = 65536,
    parameter int PIX_W      = 8,
    parameter int MEM_LAT    = 1,
    localparam int AW        = addr_w(BANK_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [9:0]                 hcount,
    input  logic [9:0]                 vcount,
    input  logic                       scale2x,
    input  logic [PIX_W-1:0]           bg_color,
`ifdef IMG_DRAWER_BORDER_EN
    input  logic [PIX_W-1:0]           border_color,
`endif
    output logic [AW-1:0]              bank_addr,
    input  logic [NUM_BANKS*PIX_W-1:0] bank_rdata,
    output logic [PIX_W-1:0]           pixel,
    output logic                       pixel_valid
);

    localparam int BW = addr_w(NUM_BANKS);
    // vld_pipe[0] = S0, [1] = S1, [VT] = aligned with bank_rdata.
    localparam int VT = BASE_LAT + MEM_LAT - 2;

    logic              mode_q;
    logic [10:0]       hx, vx, win_w, win_h;
    logic              h_in, v_in, in_win_c;
    coord_t            dh, dv, src_col_q, src_row_q;
    logic [VT:0]       vld_pipe;
    logic [31:0]       linear_c, bank_full_c;
    logic              oor_c;
    logic [BW-1:0]     bank_c;
    logic [MEM_LAT:0]  oor_pipe;
    logic [MEM_LAT:0][BW-1:0] bank_pipe;
    logic              fill_c;
    logic [PIX_W-1:0]  fill_color_c;

    // Window geometry follows the frame-captured mode, not the live input.
    assign hx       = {1'b0, hcount};
    assign vx       = {1'b0, vcount};
    assign win_w    = mode_q ? 11'(2 * IMG_W) : 11'(IMG_W);
    assign win_h    = mode_q ? 11'(2 * IMG_H) : 11'(IMG_H);
    assign h_in     = (hx >= 11'(H_OFF)) && (hx < 11'(H_OFF) + win_w);
    assign v_in     = (vx >= 11'(V_OFF)) && (vx < 11'(V_OFF) + win_h);
    assign in_win_c = h_in && v_in;
    assign dh       = hcount - 10'(H_OFF);
    assign dv       = vcount - 10'(V_OFF);

    // Mode capture at frame start and S0 source-coordinate register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q    <= 1'b0;
            src_col_q <= '0;
            src_row_q <= '0;
        end else begin
            if (hcount == 10'd0 && vcount == 10'd0) mode_q <= scale2x;
            src_col_q <= mode_q ? (dh >> 1) : dh;
            src_row_q <= mode_q ? (dv >> 1) : dv;
        end
    end

    // S1: linear index split into bank number and in-bank address.
    assign linear_c    = 32'(src_row_q) * 32'(IMG_W) + 32'(src_col_q);
    assign bank_full_c = linear_c >> AW;
    assign oor_c       = bank_full_c >= 32'(NUM_BANKS);
    assign bank_c      = bank_full_c[BW-1:0];

    // S1 address register plus flag/bank delay lines matched to MEM_LAT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_addr <= '0;
            vld_pipe  <= '0;
            oor_pipe  <= '0;
            bank_pipe <= '0;
        end else begin
            bank_addr <= (vld_pipe[0] && !oor_c) ? linear_c[AW-1:0] : '0;
            vld_pipe  <= {vld_pipe[VT-1:0], in_win_c};
            oor_pipe  <= {oor_pipe[MEM_LAT-1:0], oor_c};
            bank_pipe <= {bank_pipe[MEM_LAT-1:0], bank_c};
        end
    end

`ifdef IMG_DRAWER_BORDER_EN
    logic        h_ring, v_ring, brd_c;
    logic [VT:0] brd_pipe;

    assign h_ring = (hx + 11'd1 >= 11'(H_OFF)) && (hx <= 11'(H_OFF) + win_w);
    assign v_ring = (vx + 11'd1 >= 11'(V_OFF)) && (vx <= 11'(V_OFF) + win_h);
    assign brd_c  = h_ring && v_ring && !in_win_c;

    // Border flag rides the same pipeline as the window flag.
    always_ff @(posedge clk) begin
        if (!rst_n) brd_pipe <= '0;
        else        brd_pipe <= {brd_pipe[VT-1:0], brd_c};
    end

    assign fill_color_c = brd_pipe[VT] ? border_color : bg_color;
`else
    assign fill_color_c = bg_color;
`endif

    assign fill_c = !(vld_pipe[VT] && !oor_pipe[MEM_LAT]);

    img_bank_mux #(
        .NUM_BANKS (NUM_BANKS),
        .PIX_W     (PIX_W),
        .SEL_W     (BW)
    ) u_mux (
        .clk         (clk),
        .rst_n       (rst_n),
        .sel         (bank_pipe[MEM_LAT]),
        .fill        (fill_c),
        .fill_color  (fill_color_c),
        .rdata       (bank_rdata),
        .pixel       (pixel),
        .pixel_valid (pixel_valid)
    );

endmodule

// File: doc/img_drawer_banked.md
# img_drawer_banked

Parametrised successor to the VGA image drawer. It maps the display raster (hcount/vcount) onto a framebuffer split across NUM_BANKS single-port ROM/RAM banks and drives a shared bank address. It selects the returning bank word and outputs one registered pixel per clock, filling outside the image window with a programmable background colour. It adds runtime 1x/2x pixel-doubling mode, frame-synchronous mode capture, and a pipelined address path with an explicit memory-latency parameter.

## Interface
- IMG_W, 320, source image width in pixels
- IMG_H, 240, source image height in pixels
- H_OFF, 112, first hcount of the image window
- V_OFF, 13, first vcount of the image window
- NUM_BANKS, 4, number of framebuffer banks (1..8)
- BANK_DEPTH, 65536, words per bank; power of two
- PIX_W, 8, pixel width
- MEM_LAT, 1, bank read latency in clocks (1..3)
- clk  in  1  pixel clock
- rst_n  in  1  synchronous, active-low reset
- hcount  in  10  current raster column
- vcount  in  10  current raster row
- scale2x  in  1  requested mode: 0 = 1x, 1 = 2x pixel doubling
- bg_color  in  PIX_W  fill colour outside the window or for out-of-range index
- bank_addr  out  log2(BANK_DEPTH)  shared read address to all banks
- bank_rdata  in  NUM_BANKS*PIX_W  concatenated bank read data, bank 0 in the LSBs
- pixel  out  PIX_W  output pixel
- pixel_valid  out  1  high when pixel comes from the framebuffer (not fill)

## Operation
- Mode capture: mode_q <= scale2x only when hcount==0 && vcount==0. All window and address logic uses mode_q, so a mid-frame toggle takes effect at the next frame.
- Window size: IMG_W x IMG_H when mode_q=0; 2*IMG_W x 2*IMG_H when mode_q=1. Origin is (H_OFF, V_OFF).
- S0 (register): in_win; src_col = (hcount-H_OFF)>>mode_q; src_row = (vcount-V_OFF)>>mode_q. Subtractions use 10-bit unsigned arithmetic and are only meaningful when in_win=1.
- S1 (register): linear = src_row*IMG_W + src_col, 32-bit. bank = linear>>log2(BANK_DEPTH); bank_addr = linear[log2(BANK_DEPTH)-1:0]; oor = (bank >= NUM_BANKS).
- bank_addr is forced to 0 when in_win=0 or oor=1.
- Delay line: in_win, oor and bank are delayed MEM_LAT clocks to align with bank_rdata.
- Output register: if the aligned in_win=1 and oor=0, pixel = bank_rdata slice[bank] and pixel_valid=1. Otherwise pixel = bg_color and pixel_valid=0.
- In 2x mode each source pixel repeats over 2 columns x 2 rows.

## Timing
- Latency from an hcount/vcount sample to its pixel is 3 + MEM_LAT clocks (4 at the default). Throughput is 1 pixel per clock, with no stalls.
- Reset value of every output is 0: pixel, pixel_valid and bank_addr. mode_q, all pipeline flags and the delay line also reset to 0.
- Reset asserted mid-line: outputs are 0 on the next clock. After release, the first 3+MEM_LAT clocks output bg_color with pixel_valid=0, because the pipeline flags are cleared.
- Window edges are inclusive at H_OFF/V_OFF and exclusive at H_OFF+width/V_OFF+height.
- A bank boundary crossing (linear = k*BANK_DEPTH) switches bank with no bubble.
- A frame-start sample where scale2x changes: the new mode applies from pixel (0,0) of that frame.

## Configuration
- IMG_DRAWER_BORDER_EN defined: adds input border_color [PIX_W]. A 1-pixel ring immediately outside the current window (mode-dependent size) outputs border_color with pixel_valid=0, using the same latency as all other pixels.
- Undefined: no border_color port, and the ring shows bg_color.

## Structure
- Package img_drawer_pkg holds:
  - pixel_t typedef (PIX_W default 8)
  - raster coordinate typedef (10 bits)
  - function clog2-based address width helper
  - constant for base pipeline depth (3)
- Sub-module img_bank_mux: registered NUM_BANKS-way slice select with fill override. It is instantiated once for the output stage.

## Test plan
- Reset for 2 clocks while raster runs -> pixel=0, pixel_valid=0, bank_addr=0 throughout. The first valid pixel appears 4 clocks after the first in-window sample.
- 1x mode, bank i returns word = (i<<6)|addr[5:0]; sample (112,13) -> bank_addr 0, pixel 0x00 after 4 clocks. Sample (113,13) -> pixel 0x01.
- Sample (111,13) and (432,13) -> pixel = bg_color 0x5A, pixel_valid=0. Sample (431,252) -> last image pixel, pixel_valid=1.
- Bank crossing: linear 65535 -> bank 0 addr 0xFFFF; next pixel linear 65536 -> bank 1 addr 0. Consecutive output clocks, no gap.
- 2x mode set before frame start: (112,13), (113,13), (112,14), (113,14) all give linear 0. (114,13) gives linear 1. Toggling scale2x mid-frame has no effect until the next (0,0).
- With IMG_DRAWER_BORDER_EN: (111,13) and (112,12) give border_color 0xFF. With MEM_LAT=3, latency is 6 clocks.
